// File: rtl/ahb_bram_ctrl.sv
//------------------------------------------------------------------------------
// ahb_bram_ctrl
//
// AHB-Lite slave that bridges onto a simple dual-port block RAM with a
// registered read port (read data one cycle after the read address) and a
// byte-enabled synchronous write port. Reads and writes complete with zero
// wait states. The one exception is a read whose address phase lands in the
// data phase of a write to the same word (read-after-write hazard).
//
// Optional feature (macro BRAM_RAW_FWD_EN):
//   defined   : the hazard is resolved by forwarding the written bytes into
//               the read data, so there is no stall.
//   undefined : the hazard costs one wait state (RD_WAIT). In that cycle the
//               read address is re-issued after the write has landed.
//
// Parameters
//   ADDR_WIDTH   RAM word-address width (depth 2**ADDR_WIDTH x 32 bits)
//
// Ports
//   HCLK         clock, all state changes on its rising edge
//   HRESETn      synchronous active-low reset
//   HSEL         slave select
//   HADDR        byte address
//   HTRANS       transfer type (bit 1 set = NONSEQ/SEQ)
//   HSIZE        transfer size
//   HWRITE       1 = write
//   HWDATA       write data (data phase)
//   HREADY       bus-level ready
//   HREADYOUT    slave ready, low only in a hazard stall cycle
//   HRESP        always OKAY
//   HRDATA       read data, zero outside a read data phase
//   BRAM_WRADDR  RAM write word address
//   BRAM_WRITE   RAM byte write enables
//   BRAM_WDATA   RAM write data
//   BRAM_RDADDR  RAM read word address (registered inside the RAM)
//   BRAM_RDATA   RAM read data
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no data phase in progress
// WR_DP   | write data phase: RAM write issued from the registered address
// RD_DP   | read data phase: HRDATA carries RAM (or forwarded) data
// RD_WAIT | hazard stall: HREADYOUT low, read address re-issued to RAM
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module ahb_bram_ctrl #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
  output logic [3:0]            BRAM_WRITE,
  output logic [31:0]           BRAM_WDATA,
  output logic [ADDR_WIDTH-1:0] BRAM_RDADDR,
  input  logic [31:0]           BRAM_RDATA
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DP   = 2'd1,
    RD_DP   = 2'd2,
    RD_WAIT = 2'd3
  } state_t;

  state_t                  state_q;
  state_t                  state_d;

  logic                    addr_acc;
  logic [ADDR_WIDTH-1:0]   haddr_word;
  logic [3:0]              haddr_lanes;
  logic                    raw_hit;

  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [3:0]              wr_lanes_q;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;

`ifdef BRAM_RAW_FWD_EN
  logic                    fwd_vld_q;
  logic [31:0]             fwd_data_q;
  logic [3:0]              fwd_lanes_q;
`endif

  // Upper address bits and the SEQ/NONSEQ distinction carry no meaning here.
  logic                    unused_ok;
  assign unused_ok = &{1'b0, HTRANS[0], HADDR[31:ADDR_WIDTH+2]};

  assign addr_acc   = HSEL & HREADY & HTRANS[1];
  assign haddr_word = HADDR[ADDR_WIDTH+1:2];

  // Unaligned size/address combinations are not errored; they just get
  // these lanes.
  always_comb begin
    haddr_lanes = 4'b1111;
    case (HSIZE)
      3'd0:    haddr_lanes = 4'b0001 << HADDR[1:0];
      3'd1:    haddr_lanes = HADDR[1] ? 4'b1100 : 4'b0011;
      default: haddr_lanes = 4'b1111;
    endcase
  end

  // Read address phase overlapping a write data phase to the same word: the
  // RAM read issued this cycle would still see the old word.
  assign raw_hit = addr_acc & ~HWRITE & (state_q == WR_DP) &
                   (haddr_word == wr_addr_q);

  always_comb begin
    state_d     = IDLE;
    HREADYOUT   = 1'b1;
    HRESP       = 1'b0;
    HRDATA      = 32'h0;
    BRAM_WRADDR = wr_addr_q;
    BRAM_WDATA  = HWDATA;
    BRAM_WRITE  = 4'b0000;
    BRAM_RDADDR = haddr_word;

    if (state_q == RD_WAIT) begin
      state_d = RD_DP;
    end else if (addr_acc) begin
      if (HWRITE) begin
        state_d = WR_DP;
      end else if (raw_hit) begin
`ifdef BRAM_RAW_FWD_EN
        state_d = RD_DP;
`else
        state_d = RD_WAIT;
`endif
      end else begin
        state_d = RD_DP;
      end
    end

    // Gating with HRESETn drops a write whose data phase meets reset; the
    // state register only clears at the end of that cycle.
    if ((state_q == WR_DP) && HRESETn) begin
      BRAM_WRITE = wr_lanes_q;
    end

    if (state_q == RD_WAIT) begin
      HREADYOUT   = 1'b0;
      BRAM_RDADDR = rd_addr_q;
    end

    if (state_q == RD_DP) begin
      HRDATA = BRAM_RDATA;
`ifdef BRAM_RAW_FWD_EN
      for (int i = 0; i < 4; i++) begin
        if (fwd_vld_q && fwd_lanes_q[i]) begin
          HRDATA[8*i +: 8] = fwd_data_q[8*i +: 8];
        end
      end
`endif
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= IDLE;
      wr_addr_q   <= '0;
      wr_lanes_q  <= 4'b0000;
      rd_addr_q   <= '0;
`ifdef BRAM_RAW_FWD_EN
      fwd_vld_q   <= 1'b0;
      fwd_data_q  <= 32'h0;
      fwd_lanes_q <= 4'b0000;
`endif
    end else begin
      state_q <= state_d;
      if (addr_acc && HWRITE) begin
        wr_addr_q  <= haddr_word;
        wr_lanes_q <= haddr_lanes;
      end
      if (addr_acc && !HWRITE) begin
        rd_addr_q <= haddr_word;
      end
`ifdef BRAM_RAW_FWD_EN
      // Snapshot the write as it lands so the next read data phase can
      // overlay it on the stale RAM word.
      fwd_vld_q <= raw_hit;
      if (raw_hit) begin
        fwd_data_q  <= HWDATA;
        fwd_lanes_q <= wr_lanes_q;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
`timescale 1ns/1ps

module tb_ahb_bram_ctrl;

  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;
`ifdef BRAM_RAW_FWD_EN
  localparam int EXP_RAW_STALLS = 0;
`else
  localparam int EXP_RAW_STALLS = 1;
`endif

  logic          hclk = 1'b0;
  logic          hresetn;
  logic          hsel;
  logic [31:0]   haddr;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic          hwrite;
  logic [31:0]   hwdata;
  logic          hready;
  logic          hreadyout;
  logic          hresp;
  logic [31:0]   hrdata;
  logic [AW-1:0] bram_wraddr;
  logic [3:0]    bram_write;
  logic [31:0]   bram_wdata;
  logic [AW-1:0] bram_rdaddr;
  logic [31:0]   bram_rdata;

  always #5 hclk = ~hclk;

  // Single slave on the bus.
  assign hready = hreadyout;

  ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .HCLK        (hclk),
    .HRESETn     (hresetn),
    .HSEL        (hsel),
    .HADDR       (haddr),
    .HTRANS      (htrans),
    .HSIZE       (hsize),
    .HWRITE      (hwrite),
    .HWDATA      (hwdata),
    .HREADY      (hready),
    .HREADYOUT   (hreadyout),
    .HRESP       (hresp),
    .HRDATA      (hrdata),
    .BRAM_WRADDR (bram_wraddr),
    .BRAM_WRITE  (bram_write),
    .BRAM_WDATA  (bram_wdata),
    .BRAM_RDADDR (bram_rdaddr),
    .BRAM_RDATA  (bram_rdata)
  );

  // Block RAM: registered read address, read-before-write on a collision.
  logic [31:0] ram [0:DEPTH-1];
  always @(posedge hclk) begin
    bram_rdata <= ram[bram_rdaddr];
    for (int b = 0; b < 4; b++)
      if (bram_write[b]) ram[bram_wraddr][8*b +: 8] <= bram_wdata[8*b +: 8];
  end

  // Reference: a flat byte-addressed memory updated in transfer order.
  logic [7:0] ref_b [0:4*DEPTH-1];

  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0]    lanes;
    logic [31:0]   data;
  } wr_exp_t;

  wr_exp_t     wq[$];
  logic [31:0] rq[$];

  int          total = 0;
  int          bad = 0;
  int          stalls = 0;
  int          wr_pulses = 0;
  logic [3:0]  last_lanes = 4'b0;
  logic [31:0] last_rdata = 32'h0;
  bit          dp_rd = 1'b0;
  bit          dp_wr = 1'b0;
  logic [31:0] pend_wd = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bytes touched by a naturally sized access: a block of 1, 2 or 4 bytes
  // aligned down to its own size.
  function automatic logic [3:0] touched(input logic [31:0] a, input logic [2:0] sz);
    int n;
    int first;
    logic [3:0] m;
    n = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
    first = (int'(a[1:0]) / n) * n;
    m = 4'b0;
    for (int b = 0; b < 4; b++) m[b] = (b >= first) && (b < first + n);
    return m;
  endfunction

  function automatic int byte_base(input logic [31:0] a);
    return int'(a[AW+1:2]) * 4;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = ref_b[byte_base(a) + b];
    return w;
  endfunction

  // One address phase, starting just after a rising edge; HWDATA carries the
  // data of the previous accepted write.
  task automatic xfer(input bit sel, input bit [1:0] trans, input bit wr,
                      input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    bit rdy;
    int n;
    logic [3:0] m;
    wr_exp_t e;
    hsel = sel; htrans = trans; hwrite = wr; haddr = a; hsize = sz; hwdata = pend_wd;
    rdy = 1'b0;
    n = 0;
    while (!rdy && n < 20) begin
      @(negedge hclk);
      rdy = hreadyout;
      @(posedge hclk);
      #1;
      n++;
    end
    check("addr_phase_ready", {31'b0, rdy}, 32'd1);
    pend_wd = $urandom;
    if (sel && trans[1]) begin
      if (wr) begin
        m = touched(a, sz);
        for (int b = 0; b < 4; b++)
          if (m[b]) ref_b[byte_base(a) + b] = wd[8*b +: 8];
        e.addr = a[AW+1:2];
        e.lanes = m;
        e.data = wd;
        wq.push_back(e);
        pend_wd = wd;
      end else begin
        rq.push_back(ref_word(a));
      end
    end
  endtask

  task automatic wr_t(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    xfer(1'b1, 2'b10, 1'b1, a, sz, wd);
  endtask

  task automatic rd_t(input logic [31:0] a);
    xfer(1'b1, 2'b10, 1'b0, a, 3'd2, 32'h0);
  endtask

  task automatic idle_t();
    xfer(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0);
  endtask

  // Monitor: follows the bus pipeline on its own and checks every data phase.
  always @(negedge hclk) begin
    wr_exp_t we;
    logic [31:0] re;
    if (bram_write != 4'b0) begin
      wr_pulses++;
      last_lanes = bram_write;
    end
    if (!hresetn) begin
      if (dp_wr) begin
        check("rst_drop_write", {28'b0, bram_write}, 32'h0);
        if (wq.size() > 0) void'(wq.pop_front());
      end
      if (dp_rd && rq.size() > 0) void'(rq.pop_front());
      dp_rd = 1'b0;
      dp_wr = 1'b0;
    end else begin
      check("hresp", {31'b0, hresp}, 32'h0);
      if (dp_wr) begin
        if (wq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wq_underflow: write data phase with nothing expected at %0t", $time);
        end else begin
          we = wq.pop_front();
          check("wr_lanes", {28'b0, bram_write}, {28'b0, we.lanes});
          check("wr_addr", 32'(bram_wraddr), 32'(we.addr));
          check("wr_data", bram_wdata, we.data);
        end
      end else begin
        check("no_write", {28'b0, bram_write}, 32'h0);
      end
      if (dp_rd && !hreadyout) begin
        stalls++;
        check("stall_rdata", hrdata, 32'h0);
      end else begin
        check("hreadyout", {31'b0, hreadyout}, 32'd1);
        if (dp_rd) begin
          if (rq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rq_underflow: read data phase with nothing expected at %0t", $time);
          end else begin
            re = rq.pop_front();
            check("rdata", hrdata, re);
          end
          last_rdata = hrdata;
        end else begin
          check("idle_rdata", hrdata, 32'h0);
        end
      end
      if (hreadyout) begin
        dp_rd = hsel & htrans[1] & ~hwrite;
        dp_wr = hsel & htrans[1] & hwrite;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int w0;
    logic [31:0] saved;
    for (int i = 0; i < DEPTH; i++) ram[i] = 32'h0;
    for (int i = 0; i < 4*DEPTH; i++) ref_b[i] = 8'h0;
    hresetn = 1'b0; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    haddr = 32'h0; hsize = 3'd0; hwdata = 32'h0;
    repeat (3) @(posedge hclk);
    #1 hresetn = 1'b1;
    @(negedge hclk);
    check("rst_hreadyout", {31'b0, hreadyout}, 32'd1);
    check("rst_hresp", {31'b0, hresp}, 32'h0);
    check("rst_hrdata", hrdata, 32'h0);
    check("rst_bram_write", {28'b0, bram_write}, 32'h0);
    @(posedge hclk);
    #1;

    // Word write then idle-separated read.
    s0 = stalls;
    wr_t(32'h100, 3'd2, 32'hDEADBEEF);
    idle_t();
    rd_t(32'h100);
    idle_t();
    check("word_rdback", last_rdata, 32'hDEADBEEF);
    check("word_no_stall", stalls - s0, 0);

    // Byte write into an existing word.
    wr_t(32'h100, 3'd2, 32'h11223344);
    idle_t();
    w0 = wr_pulses;
    wr_t(32'h103, 3'd0, 32'hAA000000);
    idle_t();
    check("byte_pulses", wr_pulses - w0, 1);
    check("byte_lanes", {28'b0, last_lanes}, 32'h8);
    rd_t(32'h100);
    idle_t();
    check("byte_rdback", last_rdata, 32'hAA223344);

    // Halfword write with back-to-back read of the same word.
    wr_t(32'h100, 3'd2, 32'h11223344);
    idle_t();
    s0 = stalls;
    wr_t(32'h102, 3'd1, 32'h55660000);
    rd_t(32'h100);
    idle_t();
    idle_t();
    check("raw_stalls", stalls - s0, EXP_RAW_STALLS);
    check("raw_rdata", last_rdata, 32'h55663344);

    // Back-to-back write and read of different words.
    wr_t(32'h204, 3'd2, 32'hCAFEF00D);
    idle_t();
    s0 = stalls;
    wr_t(32'h200, 3'd2, 32'h01020304);
    rd_t(32'h204);
    idle_t();
    check("diff_word_no_stall", stalls - s0, 0);
    check("diff_word_rdata", last_rdata, 32'hCAFEF00D);

    // Reset during the data phase of a write.
    wr_t(32'h300, 3'd2, 32'h12345678);
    idle_t();
    saved = ref_word(32'h300);
    w0 = wr_pulses;
    wr_t(32'h300, 3'd2, 32'h99999999);
    hresetn = 1'b0; hsel = 1'b0; htrans = 2'b00; hwdata = 32'h99999999;
    @(posedge hclk);
    #1 hresetn = 1'b1;
    for (int b = 0; b < 4; b++) ref_b[byte_base(32'h300) + b] = saved[8*b +: 8];
    check("rst_write_pulses", wr_pulses - w0, 0);
    rd_t(32'h300);
    idle_t();
    check("rst_word_kept", last_rdata, 32'h12345678);

    // Write-shaped transfer with HSEL low.
    w0 = wr_pulses;
    xfer(1'b0, 2'b10, 1'b1, 32'h100, 3'd2, 32'hFFFFFFFF);
    idle_t();
    check("unselected_pulses", wr_pulses - w0, 0);

    // Randomized traffic concentrated on a few words to provoke hazards.
    for (int k = 0; k < 400; k++) begin
      bit s;
      bit [1:0] t;
      bit w;
      logic [31:0] hi;
      logic [31:0] a;
      logic [2:0] sz;
      int word;
      s = ($urandom_range(0, 9) != 0);
      t = ($urandom_range(0, 3) != 0) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1));
      w = $urandom_range(0, 1) != 0;
      word = ($urandom_range(0, 7) == 0) ? $urandom_range(0, DEPTH - 1) : 32'h40 + $urandom_range(0, 7);
      hi = $urandom;
      a = {hi[31:AW+2], 14'(word), 2'($urandom_range(0, 3))};
      sz = 3'($urandom_range(0, 3));
      xfer(s, t, w, a, sz, $urandom);
    end
    idle_t();
    idle_t();
    idle_t();
    check("rq_drain", rq.size(), 0);
    check("wq_drain", wq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
